// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: data-memory handshake, byte masks and load formatting.
// Build option: MEM_MISALIGN_TRAP_EN flags misaligned accesses instead of aligning them.
module mem_stage_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] rs2_data_i,
  input  logic        adv_i,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  output logic [31:0] mem_data_out_o,
  output logic        mem_stall_o,
  output logic        misalign_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] dout_q, dout_d;
  logic [2:0]  f3_q, f3_d;
  logic [3:0]  mbe_q, mbe_d;
  logic        wr_q, wr_d;

  logic        access, is_h, is_w, trap;
  logic [31:0] a_eff, st_wdata, ld_shift, ld_fmt;
  logic [3:0]  st_mbe;

  assign access = valid_i & (mem_read_i | mem_write_i);
  assign is_h   = funct3_i[1:0] == 2'b01;
  assign is_w   = funct3_i[1:0] == 2'b10;

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis;
  assign mis   = (is_h & alu_out_i[0]) | (is_w & |alu_out_i[1:0]);
  assign trap  = access & mis;
  assign a_eff = alu_out_i;
`else
  assign trap  = 1'b0;
  // Low address bits forced to the access size.
  assign a_eff = {alu_out_i[31:2],
                  alu_out_i[1] & ~is_w,
                  alu_out_i[0] & ~is_h & ~is_w};
`endif

  always_comb begin
    st_mbe   = 4'b1111;
    st_wdata = rs2_data_i;
    unique case (funct3_i[1:0])
      2'b00: begin
        st_mbe   = 4'b0001 << a_eff[1:0];
        st_wdata = {4{rs2_data_i[7:0]}};
      end
      2'b01: begin
        st_mbe   = 4'b0011 << {a_eff[1], 1'b0};
        st_wdata = {2{rs2_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_shift = dmem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld_fmt = ld_shift;
    unique case (f3_q)
      3'b000:  ld_fmt = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_fmt = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_fmt = {24'd0, ld_shift[7:0]};
      3'b101:  ld_fmt = {16'd0, ld_shift[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mbe_d        = mbe_q;
    f3_d         = f3_q;
    wr_d         = wr_q;
    dout_d       = dout_q;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_address = 32'd0;
    dmem_wdata   = 32'd0;
    dmem_mbe     = 4'd0;
    mem_stall_o  = 1'b0;
    misalign_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trap) begin
          misalign_o = 1'b1;
        end else if (access) begin
          dmem_read    = mem_read_i;
          dmem_write   = mem_write_i;
          dmem_address = {a_eff[31:2], 2'b00};
          dmem_wdata   = st_wdata;
          dmem_mbe     = st_mbe;
          mem_stall_o  = 1'b1;
          addr_d       = a_eff;
          wdata_d      = st_wdata;
          mbe_d        = st_mbe;
          f3_d         = funct3_i;
          wr_d         = mem_write_i;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        dmem_address = {addr_q[31:2], 2'b00};
        dmem_wdata   = wdata_q;
        dmem_mbe     = mbe_q;
        mem_stall_o  = 1'b1;
        if (dmem_resp) begin
          if (!wr_q) dout_d = ld_fmt;
          state_d = DONE;
        end else begin
          dmem_read  = ~wr_q;
          dmem_write = wr_q;
        end
      end
      DONE: begin
        // Holding here keeps a stalled instruction from re-issuing.
        if (adv_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      mbe_q   <= 4'd0;
      f3_q    <= 3'd0;
      wr_q    <= 1'b0;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mbe_q   <= mbe_d;
      f3_q    <= f3_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
    end
  end

  assign mem_data_out_o = dout_q;
endmodule
